// File: rtl/bcd_scan_counter_pkg.sv
// -----------------------------------------------------------------------------
// bcd_scan_counter_pkg
// Shared definitions for the BCD scan counter:
//   DIGIT_W      width of one BCD digit
//   DIGIT_MAX    largest legal digit value (9)
//   SEG_TABLE    7-segment patterns for digits 0..9 (bit0=a .. bit6=g, active high)
//   SEG_BLANK    pattern shown for the illegal codes 10..15
//   seg_decode() digit -> segment pattern lookup
// -----------------------------------------------------------------------------
package bcd_scan_counter_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic [6:0] SEG_TABLE [10] = '{
      7'b0111111,   // 0
      7'b0000110,   // 1
      7'b1011011,   // 2
      7'b1001111,   // 3
      7'b1100110,   // 4
      7'b1101101,   // 5
      7'b1111101,   // 6
      7'b0000111,   // 7
      7'b1111111,   // 8
      7'b1101111    // 9
   };

   function automatic logic [6:0] seg_decode(input logic [DIGIT_W-1:0] digit);
      logic [6:0] pattern;
      pattern = SEG_BLANK;
      if (digit <= DIGIT_MAX) begin
         pattern = SEG_TABLE[digit];
      end
      return pattern;
   endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// -----------------------------------------------------------------------------
// bcd_digit_cell
// One decade of the cascaded BCD counter. Steps by one when 'step' is high and
// reports a carry (counting up, 9 -> 0) or borrow (counting down, 0 -> 9) on
// 'carry' in the same cycle, which is used as the next decade's 'step'.
//
// Optional feature: BCD_SCAN_COUNTER_DOWN_EN adds the up_dn port and the borrow
// path; without it the cell counts up only.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (value -> 0)
//   clear  in   synchronous zero, overrides step
//   step   in   advance this digit by one
//   up_dn  in   1 = up, 0 = down (only with BCD_SCAN_COUNTER_DOWN_EN)
//   value  out  current digit 0..9
//   carry  out  combinational carry/borrow to the next digit
// -----------------------------------------------------------------------------
module bcd_digit_cell
   import bcd_scan_counter_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               step,
`ifdef BCD_SCAN_COUNTER_DOWN_EN
   input  logic               up_dn,
`endif
   output logic [DIGIT_W-1:0] value,
   output logic               carry
);

   logic               at_limit;
   logic [DIGIT_W-1:0] next_value;

`ifdef BCD_SCAN_COUNTER_DOWN_EN
   assign at_limit   = up_dn ? (value == DIGIT_MAX) : (value == '0);
   assign next_value = up_dn ? (at_limit ? '0 : value + DIGIT_W'(1))
                             : (at_limit ? DIGIT_MAX : value - DIGIT_W'(1));
`else
   assign at_limit   = (value == DIGIT_MAX);
   assign next_value = at_limit ? '0 : value + DIGIT_W'(1);
`endif

   assign carry = step & at_limit;

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge values of its neighbours, exactly like the hardware does.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else if (clear) begin
         value <= '0;
      end else if (step) begin
         value <= next_value;
      end
   end

endmodule

// File: rtl/bcd_scan_counter.sv
// -----------------------------------------------------------------------------
// bcd_scan_counter
// Prescaled, cascaded BCD counter with a multiplexed 7-segment scan output.
// A prescaler divides clk down to one digit step every (terminal+1) cycles;
// a free-running scan counter rotates the displayed digit.
//
// Optional feature: define BCD_SCAN_COUNTER_DOWN_EN to honour up_dn (count
// down with borrow). Default build counts up only and ignores up_dn.
//
// Parameters:
//   NUM_DIGITS     number of BCD digits (1..8)
//   PRESCALE_W     prescaler width (>= 18)
//   DEFAULT_COUNT  terminal count used when cfg_count == 0
//   SCAN_W         scan divider width; display advances every 2**SCAN_W cycles
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   ena        in   block enable; low freezes all state including scan
//   cfg_count  in   terminal count = {cfg_count, 10'b0}; 0 selects DEFAULT_COUNT
//   up_dn      in   1 = up, 0 = down (BCD_SCAN_COUNTER_DOWN_EN only)
//   pause      in   hold prescaler and digits; scan keeps running
//   clear      in   synchronous zero of prescaler and digits (beats pause)
//   bcd_out    out  digit values, digit 0 in the LSBs
//   seg        out  registered segments of the selected digit
//   digit_sel  out  registered one-hot selected digit
//   tick       out  one-cycle pulse in the cycle new digits appear
//   wrap       out  one-cycle pulse when the whole count wraps
// -----------------------------------------------------------------------------
module bcd_scan_counter
   import bcd_scan_counter_pkg::*;
#(
   parameter int                    NUM_DIGITS    = 4,
   parameter int                    PRESCALE_W    = 24,
   parameter logic [PRESCALE_W-1:0] DEFAULT_COUNT = 24'd10_000_000,
   parameter int                    SCAN_W        = 10
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ena,
   input  logic [7:0]                    cfg_count,
   input  logic                          up_dn,
   input  logic                          pause,
   input  logic                          clear,
   output logic [DIGIT_W*NUM_DIGITS-1:0] bcd_out,
   output logic [6:0]                    seg,
   output logic [NUM_DIGITS-1:0]         digit_sel,
   output logic                          tick,
   output logic                          wrap
);

   // Three bits index up to eight digits.
   localparam int                IDX_W    = 3;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   logic [PRESCALE_W-1:0] presc;
   logic [PRESCALE_W-1:0] terminal;
   logic                  term_hit;
   logic                  step;

   logic [SCAN_W-1:0]     scan_cnt;
   logic [IDX_W-1:0]      scan_idx;
   logic [IDX_W-1:0]      idx_next;
   logic [NUM_DIGITS-1:0] sel_next;
   logic [DIGIT_W-1:0]    sel_digit;

   logic [DIGIT_W-1:0]    digit      [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] cell_step;
   logic [NUM_DIGITS-1:0] cell_carry;
   logic                  cell_clear;

   // ---------------------------------------------------------------- prescaler
   // Terminal follows cfg_count every cycle. '>=' rather than '==' lets a
   // terminal lowered below the running count still end the period at once.
   assign terminal = (cfg_count == 8'd0) ? DEFAULT_COUNT
                                         : PRESCALE_W'({cfg_count, 10'b0});
   assign term_hit = (presc >= terminal);
   assign step     = ena & ~clear & ~pause & term_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
      end else if (ena) begin
         if (clear) begin
            presc <= '0;
         end else if (!pause) begin
            presc <= term_hit ? '0 : presc + PRESCALE_W'(1);
         end
      end
   end

   // ------------------------------------------------------------- digit chain
   assign cell_clear   = ena & clear;
   assign cell_step[0] = step;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      if (g > 0) begin : g_chain
         assign cell_step[g] = cell_carry[g-1];
      end

      bcd_digit_cell u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .clear (cell_clear),
         .step  (cell_step[g]),
`ifdef BCD_SCAN_COUNTER_DOWN_EN
         .up_dn (up_dn),
`endif
         .value (digit[g]),
         .carry (cell_carry[g])
      );

      assign bcd_out[g*DIGIT_W +: DIGIT_W] = digit[g];
   end

`ifndef BCD_SCAN_COUNTER_DOWN_EN
   logic unused_up_dn;
   assign unused_up_dn = up_dn;
`endif

   // The registered tick lines up with the cycle in which the stepped digits
   // first appear on bcd_out; wrap is the carry out of the top digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick <= 1'b0;
         wrap <= 1'b0;
      end else begin
         tick <= step;
         wrap <= step & cell_carry[NUM_DIGITS-1];
      end
   end

   // ----------------------------------------------------------------- scanning
   // seg is decoded from the digit at the index being loaded this cycle, so
   // seg and digit_sel always change together.
   // NOTE: every always_comb output gets a default first so no path can leave
   // it unassigned and infer a latch.
   always_comb begin
      idx_next  = scan_idx;
      sel_next  = '0;
      sel_digit = '0;
      if (&scan_cnt) begin
         idx_next = (scan_idx == LAST_IDX) ? '0 : scan_idx + IDX_W'(1);
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_next == IDX_W'(i)) begin
            sel_next[i] = 1'b1;
            sel_digit   = digit[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt  <= '0;
         scan_idx  <= '0;
         digit_sel <= NUM_DIGITS'(1);
         seg       <= seg_decode(4'd0);
      end else if (ena) begin
         scan_cnt  <= scan_cnt + SCAN_W'(1);
         scan_idx  <= idx_next;
         digit_sel <= sel_next;
         seg       <= seg_decode(sel_digit);
      end
   end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_scan_counter
// Self-checking bench for bcd_scan_counter. A behavioural model tracks the
// count as a plain integer (0..9999), the prescaler and scan position as
// integers, and is compared against the DUT on every falling edge. A vector
// table plus hand-written sequences cover the corner cases with fixed
// expectations. DEFAULT_COUNT is set to 1 so cfg_count==0 gives fast counting.
// -----------------------------------------------------------------------------
module tb_bcd_scan_counter;

   localparam int N     = 4;
   localparam int SW    = 10;
   localparam int DEF   = 1;
   localparam int MODV  = 10000;
   localparam int SCANM = 1 << SW;

   localparam logic [6:0] SEG_REF [10] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ena = 1'b1;
   logic [7:0]    cfg_count = 8'd1;
   logic          up_dn = 1'b1;
   logic          pause = 1'b0;
   logic          clear = 1'b0;
   logic [4*N-1:0] bcd_out;
   logic [6:0]    seg;
   logic [N-1:0]  digit_sel;
   logic          tick;
   logic          wrap;

   bcd_scan_counter #(
      .NUM_DIGITS    (N),
      .PRESCALE_W    (24),
      .DEFAULT_COUNT (24'd1),
      .SCAN_W        (SW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .cfg_count (cfg_count),
      .up_dn     (up_dn),
      .pause     (pause),
      .clear     (clear),
      .bcd_out   (bcd_out),
      .seg       (seg),
      .digit_sel (digit_sel),
      .tick      (tick),
      .wrap      (wrap)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------ model
   function automatic int digit_of(input int v, input int i);
      return (v / (10 ** i)) % 10;
   endfunction

   function automatic logic [4*N-1:0] bcd_of(input int v);
      logic [4*N-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) r[4*i +: 4] = 4'(digit_of(v, i));
      return r;
   endfunction

   int         m_presc = 0;
   int         m_cnt   = 0;
   int         m_scan  = 0;
   int         m_idx   = 0;
   logic       m_tick  = 1'b0;
   logic       m_wrap  = 1'b0;
   logic [6:0] m_seg   = 7'h3F;

   always @(posedge clk or negedge rst_n) begin : model
      int term;
      int nidx;
      bit up;
      if (!rst_n) begin
         m_presc <= 0; m_cnt <= 0; m_scan <= 0; m_idx <= 0;
         m_tick <= 1'b0; m_wrap <= 1'b0; m_seg <= SEG_REF[0];
      end else if (ena) begin
         term = (cfg_count == 8'd0) ? DEF : int'(cfg_count) * 1024;
         nidx = (m_scan == SCANM - 1) ? (m_idx + 1) % N : m_idx;
         m_scan <= (m_scan + 1) % SCANM;
         m_idx  <= nidx;
         m_seg  <= SEG_REF[digit_of(m_cnt, nidx)];
`ifdef BCD_SCAN_COUNTER_DOWN_EN
         up = up_dn;
`else
         up = 1'b1;
`endif
         if (clear) begin
            m_presc <= 0; m_cnt <= 0; m_tick <= 1'b0; m_wrap <= 1'b0;
         end else if (pause) begin
            m_tick <= 1'b0; m_wrap <= 1'b0;
         end else if (m_presc >= term) begin
            m_presc <= 0;
            m_tick  <= 1'b1;
            if (up) begin
               m_wrap <= (m_cnt == MODV - 1);
               m_cnt  <= (m_cnt + 1) % MODV;
            end else begin
               m_wrap <= (m_cnt == 0);
               m_cnt  <= (m_cnt + MODV - 1) % MODV;
            end
         end else begin
            m_presc <= m_presc + 1;
            m_tick  <= 1'b0;
            m_wrap  <= 1'b0;
         end
      end else begin
         m_tick <= 1'b0;
         m_wrap <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("mdl_bcd",  bcd_out,   bcd_of(m_cnt));
         check("mdl_tick", tick,      m_tick);
         check("mdl_wrap", wrap,      m_wrap);
         check("mdl_seg",  seg,       m_seg);
         check("mdl_sel",  digit_sel, N'(1) << m_idx);
      end
   end

   // ---------------------------------------------------------------- helpers
   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_bcd(input string name, input logic [4*N-1:0] target, input int budget);
      int k = 0;
      while (bcd_out !== target && k < budget) begin
         run(1);
         k++;
      end
      check(name, bcd_out, target);
   endtask

   task automatic wait_tick(input string name, input int budget);
      int k = 0;
      do begin
         run(1);
         k++;
      end while (tick !== 1'b1 && k < budget);
      check(name, tick, 1'b1);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      run(1);
      clear = 1'b0;
   endtask

   typedef struct {
      int             cycles;
      bit             pause;
      bit             clear;
      logic [4*N-1:0] exp_bcd;
      logic           exp_tick;
      logic [N-1:0]   exp_sel;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int changes;
      logic [N-1:0] last_sel;
      bit tick_seen;

      // Table: cfg_count=1 -> terminal 1024, tick every 1025 cycles; scan
      // advances every 1024 cycles. Cycle counts are relative to the previous row.
      vecs[0] = '{1024, 1'b0, 1'b0, 16'h0000, 1'b0, 4'b0010};
      vecs[1] = '{1,    1'b0, 1'b0, 16'h0001, 1'b1, 4'b0010};
      vecs[2] = '{1,    1'b0, 1'b0, 16'h0001, 1'b0, 4'b0010};
      vecs[3] = '{1022, 1'b0, 1'b0, 16'h0001, 1'b0, 4'b0100};
      vecs[4] = '{1,    1'b0, 1'b0, 16'h0001, 1'b0, 4'b0100};
      vecs[5] = '{1,    1'b0, 1'b0, 16'h0002, 1'b1, 4'b0100};
      vecs[6] = '{3000, 1'b1, 1'b0, 16'h0002, 1'b0, 4'b0001};
      vecs[7] = '{1,    1'b0, 1'b1, 16'h0000, 1'b0, 4'b0001};

      // Reset state while rst_n is held low.
      #12;
      check("rst_bcd",  bcd_out,   16'h0000);
      check("rst_seg",  seg,       7'b0111111);
      check("rst_sel",  digit_sel, 4'b0001);
      check("rst_tick", tick,      1'b0);
      check("rst_wrap", wrap,      1'b0);
      #10 rst_n = 1'b1;

      foreach (vecs[i]) begin
         pause = vecs[i].pause;
         clear = vecs[i].clear;
         run(vecs[i].cycles);
         check($sformatf("vec%0d_bcd", i),  bcd_out,   vecs[i].exp_bcd);
         check($sformatf("vec%0d_tick", i), tick,      vecs[i].exp_tick);
         check($sformatf("vec%0d_sel", i),  digit_sel, vecs[i].exp_sel);
      end
      pause = 1'b0;
      clear = 1'b0;

      // 0999 -> 1000, then 9999 -> 0000 with wrap.
      cfg_count = 8'd0;
      do_clear();
      wait_bcd("reach_0999", 16'h0999, 4000);
      wait_tick("tick_1000", 10);
      check("bcd_1000", bcd_out, 16'h1000);
      check("nowrap_1000", wrap, 1'b0);
      wait_bcd("reach_9999", 16'h9999, 20000);
      wait_tick("tick_wrap", 10);
      check("bcd_0000", bcd_out, 16'h0000);
      check("wrap_9999", wrap, 1'b1);
      run(1);
      check("wrap_width", wrap, 1'b0);

      // Terminal lowered below the running prescaler.
      cfg_count = 8'd8;
      do_clear();
      run(5000);
      check("pre_lower_tick", tick, 1'b0);
      cfg_count = 8'd1;
      run(1);
      check("lower_tick", tick, 1'b1);
      check("lower_bcd", bcd_out, 16'h0001);

      // clear and pause together at terminal.
      cfg_count = 8'd0;
      do_clear();
      wait_bcd("reach_0042a", 16'h0042, 200);
      cfg_count = 8'd1;
      run(1024);
      clear = 1'b1;
      pause = 1'b1;
      run(1);
      check("clrpause_bcd",  bcd_out, 16'h0000);
      check("clrpause_tick", tick,    1'b0);
      clear = 1'b0;
      pause = 1'b0;

      // pause alone holds 0042 while the scan keeps rotating.
      cfg_count = 8'd0;
      wait_bcd("reach_0042b", 16'h0042, 200);
      pause = 1'b1;
      changes = 0;
      tick_seen = 1'b0;
      last_sel = digit_sel;
      for (int c = 0; c < 5000; c++) begin
         run(1);
         if (digit_sel !== last_sel) changes++;
         if (tick === 1'b1) tick_seen = 1'b1;
         last_sel = digit_sel;
      end
      check("pause_bcd",  bcd_out, 16'h0042);
      check("pause_tick", tick_seen, 1'b0);
      check("pause_rot",  (changes >= 4 && changes <= 5), 1'b1);
      pause = 1'b0;

      // Asynchronous reset between edges, then restart from zero.
      cfg_count = 8'd1;
      #2 rst_n = 1'b0;
      #1;
      check("arst_bcd",  bcd_out,   16'h0000);
      check("arst_seg",  seg,       7'b0111111);
      check("arst_sel",  digit_sel, 4'b0001);
      check("arst_tick", tick,      1'b0);
      check("arst_wrap", wrap,      1'b0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      run(1024);
      check("restart_notick", tick, 1'b0);
      run(1);
      check("restart_tick", tick, 1'b1);
      check("restart_bcd", bcd_out, 16'h0001);

`ifdef BCD_SCAN_COUNTER_DOWN_EN
      // Down count: 0000 -> 9999 with wrap; 1000 -> 0999.
      cfg_count = 8'd0;
      do_clear();
      up_dn = 1'b0;
      wait_tick("down_tick", 10);
      check("down_bcd_9999", bcd_out, 16'h9999);
      check("down_wrap", wrap, 1'b1);
      up_dn = 1'b1;
      wait_bcd("reach_1000", 16'h1000, 4000);
      up_dn = 1'b0;
      wait_tick("down_tick2", 10);
      check("down_bcd_0999", bcd_out, 16'h0999);
      check("down_nowrap", wrap, 1'b0);
      up_dn = 1'b1;
`endif

      // Randomised traffic checked by the model.
      for (int c = 0; c < 4000; c++) begin
         ena   = ($urandom % 8) != 0;
         pause = ($urandom % 16) == 0;
         clear = ($urandom % 64) == 0;
         up_dn = $urandom % 2;
         if (c % 200 == 0) begin
            case ($urandom % 5)
               0, 1, 2: cfg_count = 8'd0;
               3:       cfg_count = 8'd1;
               default: cfg_count = 8'($urandom_range(1, 3));
            endcase
         end
         run(1);
      end
      ena = 1'b1;
      pause = 1'b0;
      clear = 1'b0;
      run(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
